// File: rtl/qspi_mem_responder.sv
// Quad-SPI memory target: oversamples the controller's SCK, answers 0xEB reads and
// 0x38 writes from an internal byte array, and drives the pads through io_out/io_dir.
module qspi_mem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_BITS   = 24,
  parameter int WAIT_CYCLES = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       qspi_cs_n,
  input  logic       qspi_sck,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  output logic [3:0] io_dir,
  output logic       active,
  output logic       cmd_err
);

  localparam int AW   = $clog2(DEPTH_BYTES);
  localparam int ANIB = ADDR_BITS / 4;
  localparam int CW   = 8;
  localparam logic [CW-1:0] WAIT_CNT = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ANIB - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE} state_t;

  state_t state_reg, state_next;

  logic cs_s1, cs_s2, cs_prev;
  logic sck_s1, sck_s2, sck_prev;
  logic [3:0] io_s1, io_s2;

  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [ADDR_BITS-1:0] shift_reg, shift_next, shift_in;
  logic [AW-1:0]        addr_reg, addr_next;
  logic [3:0]           hi_reg, hi_next;
  logic                 nib_lo_reg, nib_lo_next;
  logic                 is_read_reg, is_read_next;
  logic [3:0]           io_out_next, io_dir_next;
  logic                 cmd_err_next;

  logic [7:0] mem [DEPTH_BYTES];
  logic [7:0] rd_byte;
  logic       mem_we;
  logic [7:0] mem_wdata;

  logic cs_fall, cs_rise, sck_rise, sck_fall;

  // SCK edges only count while the synchronised CS is low, so a CS rise always wins.
  assign cs_fall  = ~cs_s2 & cs_prev;
  assign cs_rise  = cs_s2 & ~cs_prev;
  assign sck_rise = sck_s2 & ~sck_prev & ~cs_s2;
  assign sck_fall = ~sck_s2 & sck_prev & ~cs_s2;
  assign shift_in = {shift_reg[ADDR_BITS-5:0], io_s2};
  assign active   = (state_reg != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_s1       <= 1'b0;
      cs_s2       <= 1'b0;
      cs_prev     <= 1'b0;
      sck_s1      <= 1'b0;
      sck_s2      <= 1'b0;
      sck_prev    <= 1'b0;
      io_s1       <= 4'h0;
      io_s2       <= 4'h0;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      addr_reg    <= '0;
      hi_reg      <= 4'h0;
      nib_lo_reg  <= 1'b0;
      is_read_reg <= 1'b0;
      io_out      <= 4'h0;
      io_dir      <= 4'h0;
      cmd_err     <= 1'b0;
    end else begin
      cs_s1       <= qspi_cs_n;
      cs_s2       <= cs_s1;
      cs_prev     <= cs_s2;
      sck_s1      <= qspi_sck;
      sck_s2      <= sck_s1;
      sck_prev    <= sck_s2;
      io_s1       <= io_in;
      io_s2       <= io_s1;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      addr_reg    <= addr_next;
      hi_reg      <= hi_next;
      nib_lo_reg  <= nib_lo_next;
      is_read_reg <= is_read_next;
      io_out      <= io_out_next;
      io_dir      <= io_dir_next;
      cmd_err     <= cmd_err_next;
    end
  end

  // Registered read: addr settles at least two clocks before the next SCK fall uses rd_byte.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[addr_reg] <= mem_wdata;
    end
    rd_byte <= mem[addr_reg];
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    shift_next   = shift_reg;
    addr_next    = addr_reg;
    hi_next      = hi_reg;
    nib_lo_next  = nib_lo_reg;
    is_read_next = is_read_reg;
    io_out_next  = io_out;
    io_dir_next  = io_dir;
    cmd_err_next = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = {hi_reg, io_s2};

    if (cs_rise) begin
      state_next  = IDLE;
      io_dir_next = 4'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            state_next = CMD;
            cnt_next   = '0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            shift_next = shift_in;
            if (cnt_reg == CW'(1)) begin
              cnt_next = '0;
              if (shift_in[7:0] == 8'hEB) begin
                state_next   = ADDR;
                is_read_next = 1'b1;
              end else if (shift_in[7:0] == 8'h38) begin
                state_next   = ADDR;
                is_read_next = 1'b0;
              end else begin
                state_next   = IGNORE;
                cmd_err_next = 1'b1;
              end
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            shift_next = shift_in;
            if (cnt_reg == ADDR_LAST) begin
              cnt_next    = '0;
              addr_next   = shift_in[AW-1:0];
              nib_lo_next = 1'b0;
              state_next  = is_read_reg ? DUMMY : WRITE;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
        end
        DUMMY: begin
          if (sck_rise && cnt_reg != WAIT_CNT) begin
            cnt_next = cnt_reg + CW'(1);
          end else if (sck_fall && cnt_reg == WAIT_CNT) begin
            io_dir_next = 4'hF;
            io_out_next = rd_byte[7:4];
            nib_lo_next = 1'b1;
            state_next  = READ;
          end
        end
        READ: begin
          if (sck_fall) begin
            if (nib_lo_reg) begin
              io_out_next = rd_byte[3:0];
              addr_next   = addr_reg + AW'(1);
              nib_lo_next = 1'b0;
            end else begin
              io_out_next = rd_byte[7:4];
              nib_lo_next = 1'b1;
            end
          end
        end
        WRITE: begin
          if (sck_rise) begin
            if (nib_lo_reg) begin
              mem_we      = 1'b1;
              addr_next   = addr_reg + AW'(1);
              nib_lo_next = 1'b0;
            end else begin
              hi_next     = io_s2;
              nib_lo_next = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Bench acting as the QSPI controller; a byte-array model predicts each SCK rise's
// pad state and a monitor compares the DUT against that queue.
module tb_qspi_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 6;
  localparam int H     = 6;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       qspi_cs_n = 1'b1;
  logic       qspi_sck = 1'b0;
  logic [3:0] io_in = 4'h0;
  logic [3:0] io_out;
  logic [3:0] io_dir;
  logic       active;
  logic       cmd_err;

  qspi_mem_responder #(.DEPTH_BYTES(DEPTH), .ADDR_BITS(24), .WAIT_CYCLES(WAITC)) dut (
    .clock(clock), .reset_n(reset_n), .qspi_cs_n(qspi_cs_n), .qspi_sck(qspi_sck),
    .io_in(io_in), .io_out(io_out), .io_dir(io_dir), .active(active), .cmd_err(cmd_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] dir;
    logic [3:0] nib;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fails = 0;
  int         err_pulses = 0;
  logic [7:0] model_mem [DEPTH];
  logic [7:0] wbuf [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every controller SCK rise is the moment the pads are sampled.
  always @(posedge qspi_sck) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL sck_unexpected: got SCK rise, required none queued at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("io_dir", {28'h0, io_dir}, {28'h0, e.dir});
      if (e.dir == 4'hF) check("io_out", {28'h0, io_out}, {28'h0, e.nib});
      check("active", {31'h0, active}, 32'h1);
    end
  end

  always @(posedge clock) begin
    if (reset_n && cmd_err) err_pulses <= err_pulses + 1;
  end

  task automatic sck_cycle(input logic [3:0] drive, input logic [3:0] edir, input logic [3:0] enib);
    io_in = drive;
    exp_q.push_back({edir, enib});
    repeat (H) @(negedge clock);
    qspi_sck = 1'b1;
    repeat (H) @(negedge clock);
    qspi_sck = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clock);
    qspi_cs_n = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic cs_high();
    repeat (2) @(negedge clock);
    qspi_cs_n = 1'b1;
    io_in = 4'h0;
    repeat (8) @(negedge clock);
  endtask

  task automatic header(input logic [7:0] cmd, input logic [23:0] a);
    cs_low();
    sck_cycle(cmd[7:4], 4'h0, 4'h0);
    sck_cycle(cmd[3:0], 4'h0, 4'h0);
    for (int i = 5; i >= 0; i--) sck_cycle(a[4*i +: 4], 4'h0, 4'h0);
  endtask

  task automatic do_write(input logic [23:0] a, input int n);
    header(8'h38, a);
    for (int i = 0; i < n; i++) begin
      sck_cycle(wbuf[i][7:4], 4'h0, 4'h0);
      sck_cycle(wbuf[i][3:0], 4'h0, 4'h0);
      model_mem[(int'(a) + i) % DEPTH] = wbuf[i];
    end
    cs_high();
    $display("write addr=%06h len=%0d", a, n);
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [7:0] b;
    header(8'hEB, a);
    for (int i = 0; i < WAITC; i++) sck_cycle(4'h0, 4'h0, 4'h0);
    for (int i = 0; i < n; i++) begin
      b = model_mem[(int'(a) + i) % DEPTH];
      sck_cycle(4'h0, 4'hF, b[7:4]);
      sck_cycle(4'h0, 4'hF, b[3:0]);
    end
    cs_high();
    $display("read  addr=%06h len=%0d", a, n);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         pulses_before;
    int         len;
    logic [23:0] ra;
    logic [7:0]  b;

    repeat (5) @(negedge clock);
    check("reset_io_dir", {28'h0, io_dir}, 32'h0);
    check("reset_io_out", {28'h0, io_out}, 32'h0);
    check("reset_active", {31'h0, active}, 32'h0);
    check("reset_cmd_err", {31'h0, cmd_err}, 32'h0);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);

    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C; wbuf[2] = 8'h00; wbuf[3] = 8'hFF;
    do_write(24'h000010, 4);
    do_read(24'h000010, 4);
    check("idle_after_read", {31'h0, active}, 32'h0);
    check("dir_after_read", {28'h0, io_dir}, 32'h0);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(24'h0003FF, 2);
    do_read(24'h0003FF, 2);
    do_read(24'h000000, 1);

    wbuf[0] = 8'h77;
    do_write(24'h000405, 1);
    do_read(24'h000005, 1);

    wbuf[0] = 8'h5A;
    do_write(24'h000020, 1);
    header(8'h38, 24'h000020);
    sck_cycle(4'h9, 4'h0, 4'h0);
    cs_high();
    $display("partial write addr=000020 nibble=9");
    do_read(24'h000020, 1);

    pulses_before = err_pulses;
    cs_low();
    sck_cycle(4'h9, 4'h0, 4'h0);
    sck_cycle(4'hF, 4'h0, 4'h0);
    for (int i = 0; i < 16; i++) sck_cycle(4'($urandom), 4'h0, 4'h0);
    cs_high();
    check("cmd_err_cycles", err_pulses - pulses_before, 32'h1);
    $display("unknown cmd 9F");
    do_read(24'h000010, 4);

    for (int t = 0; t < 12; t++) begin
      ra  = 24'($urandom);
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) wbuf[i] = 8'($urandom);
      do_write(ra, len);
      do_read(ra, len);
    end

    header(8'hEB, 24'h000010);
    for (int i = 0; i < WAITC; i++) sck_cycle(4'h0, 4'h0, 4'h0);
    b = model_mem[16];
    sck_cycle(4'h0, 4'hF, b[7:4]);
    sck_cycle(4'h0, 4'hF, b[3:0]);
    b = model_mem[17];
    sck_cycle(4'h0, 4'hF, b[7:4]);
    @(negedge clock);
    check("pre_reset_dir", {28'h0, io_dir}, 32'hF);
    reset_n = 1'b0;
    #1;
    check("midreset_dir", {28'h0, io_dir}, 32'h0);
    check("midreset_active", {31'h0, active}, 32'h0);
    check("midreset_io_out", {28'h0, io_out}, 32'h0);
    qspi_cs_n = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
    check("post_reset_active", {31'h0, active}, 32'h0);
    $display("reset during read");
    do_read(24'h000010, 4);

    check("queue_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/qspi_mem_responder.md
Name: qspi_mem_responder

Overview:
- Synthesizable QSPI memory target that answers the ExtMemory QSPI controller on the far side of the bidirectional pads.
- Used in simulation and FPGA loopback benches as a stand-in for external PSRAM/flash.
- Drives each pad's tri-state buffer through per-line direction/output/input signals, mirroring the controller-side buffers.
- Quad mode only: command, address and data all move 4 bits per SCK.

Parameters:
- DEPTH_BYTES, 1024: internal byte array size; power of two.
- ADDR_BITS, 24: address width on the wire.
- WAIT_CYCLES, 6: dummy SCK cycles between address and read data.

Ports:
- clock  in  1  system clock; oversamples SCK.
- reset_n  in  1  asynchronous active-low reset.
- qspi_cs_n  in  1  chip select from controller, active low.
- qspi_sck  in  1  serial clock from controller.
- io_in  in  4  sampled pad values, one bit per line.
- io_out  out  4  values to drive onto the pads.
- io_dir  out  4  per-line drive enable; 1 = drive, 0 = high-Z.
- active  out  1  high while a transaction is in progress (state not IDLE).
- cmd_err  out  1  one-clock pulse when an unsupported command byte completes.

Behaviour:
- **Reset.** clock and reset_n are the only clock and reset. On reset: io_out=0, io_dir=0, active=0, cmd_err=0, state=IDLE, all counters 0. Memory contents are not reset.
- **Synchronisers.** qspi_cs_n, qspi_sck and io_in each pass through a 2-FF synchroniser.
  - SCK rise/fall is detected from the synchronised value vs its previous value.
  - SCK must be ≤ clock/4.
- **Sampling and launch.** Inputs are sampled on SCK rise. Outputs are updated on SCK fall, i.e. 1 clock after the synchronised fall is detected.
- **Nibble order.** High nibble first; io[3] is the MSB of each nibble.
- **IDLE.** Synchronised CS falls -> CMD with the nibble counter cleared.
- **CMD.** 2 rises assemble the command byte.
  - 0xEB -> ADDR (read).
  - 0x38 -> ADDR (write).
  - Anything else -> IGNORE, with a 1-cycle cmd_err pulse.
- **ADDR.** ADDR_BITS/4 rises (6 at default) assemble the address. Effective address = address mod DEPTH_BYTES (upper bits dropped).
  - Read -> DUMMY.
  - Write -> WRITE.
- **DUMMY.** Counts WAIT_CYCLES rises; io_dir stays 0 throughout.
  - On the fall after the last dummy rise: io_dir=4'hF and io_out = high nibble of mem[addr]. State -> READ.
  - WAIT_CYCLES=0: the fall after the last address rise launches data.
- **READ.** Each fall drives the next nibble. After a low nibble, addr increments, wrapping DEPTH_BYTES-1 -> 0. Continues until CS rises.
- **WRITE.** Each pair of rises forms one byte, written to mem[addr] on the second rise, then addr increments with wrap. io_dir stays 0.
- **IGNORE.** Pads stay high-Z; all SCK edges are ignored until CS rises.
- **CS rises (synchronised), any state.**
  - Same clock: state=IDLE and io_dir=0.
  - Partially received write byte (one nibble) is discarded.
  - Partially received command/address is discarded; memory is unchanged.
- **Reset mid-transaction.** Immediate return to reset values; pads released.
- **Wire-level write reads back.** A write followed by a read returns the written data.
- **SCK edges with CS high** are ignored.
- **Simultaneous CS rise and SCK rise in the same synchronised cycle:** CS wins; that edge is not sampled.

Test Plan:
- **Write/read-back.** CS low, send 0x38, addr 0x000010, data bytes A5 3C 00 FF, CS high. Then 0xEB, addr 0x000010, 6 dummies, 8 data SCKs -> nibbles A,5,3,C,0,0,F,F. io_dir=F only during the data phase; active high for both transactions.
- **Wrap-around.** Write 0x11 0x22 at addr DEPTH_BYTES-1 (0x3FF). Read at 0x3FF -> 11 22. mem[0]=0x22.
- **Address aliasing.** Write 0x77 at addr 0x000405. Read at 0x000005 -> 0x77.
- **Partial byte on abort.** 0x38, addr 0x20, send nibble 0x9 only, CS high. Read 0x20 -> previous contents unchanged.
- **Unknown command.** Send 0x9F -> cmd_err pulses exactly 1 clock. io_dir stays 0 for the remainder of CS-low with SCK toggling. A following valid read succeeds.
- **Reset mid-read.** Assert reset_n=0 during the data phase -> io_dir=0 and active=0 immediately. After release, a new read returns correct data.
